// File: rtl/iir_csa_pkg.sv
// iir_csa_pkg
// Shared definitions for the carry-propagate stage behind the IIR carry-save
// summation tree: default word and segment widths, the derived segment
// count, and the token that moves through the segmented adder pipeline.
package iir_csa_pkg;

  localparam int CSA_WIDTH = 16;
  localparam int CSA_SEG   = 4;
  localparam int CSA_NSEG  = CSA_WIDTH / CSA_SEG;

  // One pipeline token.
  //   vld   : token present in this stage
  //   opa   : sum-vector operand bits (upper segments still to be consumed)
  //   opb   : carry-vector operand bits (upper segments still to be consumed)
  //   res   : result bits resolved so far (lower segments)
  //   carry : carry out of the most recently resolved segment
  //   msb   : {sum_vec MSB, carry_vec MSB}, needed for overflow at the end
  //   ovf   : signed overflow, only meaningful in the last stage
  typedef struct packed {
    logic                 vld;
    logic [CSA_WIDTH-1:0] opa;
    logic [CSA_WIDTH-1:0] opb;
    logic [CSA_WIDTH-1:0] res;
    logic                 carry;
    logic [1:0]           msb;
    logic                 ovf;
  } csa_tok_t;

endpackage

// File: rtl/cpa_segment.sv
// cpa_segment
// SEG-bit combinational ripple-carry adder built from full_adder cells.
// Ports: a, b (SEG-bit addends), c_in (carry in);
//        sum (SEG-bit sum), c_out (carry out of the top bit).
module cpa_segment
  import iir_csa_pkg::*;
#(
  parameter int SEG = CSA_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           c_in,
  output logic [SEG-1:0] sum,
  output logic           c_out
);

  logic [SEG:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < SEG; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .c_in (c[i]),
      .sum  (sum[i]),
      .c_out(c[i+1])
    );
  end

  assign c_out = c[SEG];

endmodule

// File: rtl/full_adder.sv
// full_adder
// Single-bit full adder cell, shared with the carry-save rows upstream.
// Ports: a, b, c_in (addends and carry in); sum, c_out (sum and carry out).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/csa_resolve.sv
// csa_resolve
// Resolves the redundant sum/carry pair from the CSA tree into one
// two's-complement word using a segmented, pipelined ripple adder.
// Stage k resolves bits [k*SEG +: SEG]; the carry between segments is
// registered, so the result appears NSEG cycles after the input transfer.
// A single global stall (output valid but not accepted) freezes every stage,
// bubbles included.
//
// Optional build macro CSA_RESOLVE_SAT_EN: when defined, an overflowing
// result is clamped to the most positive / most negative value in the last
// stage (overflow is still flagged). Otherwise the result wraps.
//
// Ports:
//   clk, rst   : clock (rising edge), synchronous active-high reset
//   in_valid   : sum_vec/carry_vec pair is valid
//   in_ready   : pair is accepted this cycle
//   sum_vec    : CSA sum vector (WIDTH bits)
//   carry_vec  : CSA carry vector, already weight-aligned (WIDTH bits)
//   out_valid  : result/carry_out/overflow are valid
//   out_ready  : downstream accepts the result
//   result     : (sum_vec + carry_vec) mod 2^WIDTH (or saturated)
//   carry_out  : unsigned carry out of bit WIDTH-1
//   overflow   : signed overflow of the addition
//
// WIDTH must be a multiple of SEG and no wider than CSA_WIDTH.
module csa_resolve
  import iir_csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int SEG   = CSA_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_vec,
  input  logic [WIDTH-1:0] carry_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NSEG = WIDTH / SEG;

  logic stall;
  logic adv;

  // Clamp value for an overflowed sum: the two operands share a sign, so the
  // true result lies beyond the range on that side.
  function automatic logic [CSA_WIDTH-1:0] sat_word(input logic neg);
    logic [CSA_WIDTH-1:0] w;
    w = '0;
    if (neg) w[WIDTH-1]   = 1'b1;
    else     w[WIDTH-2:0] = '1;
    return w;
  endfunction

  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = adv;

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    csa_tok_t       src;
    csa_tok_t       nxt;
    csa_tok_t       tok_p;
    logic [SEG-1:0] seg_sum;
    logic           seg_cout;
    logic           stg_unused;

    // Stage k input: the port pair for stage 0, the previous token otherwise
    if (k == 0) begin : g_src
      always_comb begin
        src       = '0;
        src.vld   = in_valid;
        src.opa   = CSA_WIDTH'(sum_vec);
        src.opb   = CSA_WIDTH'(carry_vec);
        src.msb   = {sum_vec[WIDTH-1], carry_vec[WIDTH-1]};
      end
    end else begin : g_src
      assign src = g_stg[k-1].tok_p;
    end

    cpa_segment #(
      .SEG(SEG)
    ) u_seg (
      .a    (src.opa[k*SEG +: SEG]),
      .b    (src.opb[k*SEG +: SEG]),
      .c_in (src.carry),
      .sum  (seg_sum),
      .c_out(seg_cout)
    );

    always_comb begin
      nxt                   = src;
      nxt.res[k*SEG +: SEG] = seg_sum;
      nxt.carry             = seg_cout;
      nxt.ovf               = 1'b0;
      if (k == NSEG - 1) begin
        // seg_sum[SEG-1] is the result MSB before any clamping
        nxt.ovf = (src.msb[1] == src.msb[0]) && (seg_sum[SEG-1] != src.msb[1]);
`ifdef CSA_RESOLVE_SAT_EN
        if (nxt.ovf) nxt.res = sat_word(src.msb[1]);
`endif
      end
    end

    // Stage k register; the last stage also drives the outputs, so its
    // visible fields are cleared by reset along with the valid bit
    always_ff @(posedge clk) begin
      if (rst) begin
        tok_p.vld <= 1'b0;
        if (k == NSEG - 1) begin
          tok_p.res   <= '0;
          tok_p.carry <= 1'b0;
          tok_p.ovf   <= 1'b0;
        end
      end else if (adv) begin
        tok_p <= nxt;
      end
    end

    // Consumed operand bits are not read downstream; this sink keeps the
    // token a single whole-word register
    assign stg_unused = ^tok_p;
  end

  assign out_valid = g_stg[NSEG-1].tok_p.vld;
  assign result    = g_stg[NSEG-1].tok_p.res[WIDTH-1:0];
  assign carry_out = g_stg[NSEG-1].tok_p.carry;
  assign overflow  = g_stg[NSEG-1].tok_p.ovf;

endmodule

// File: tb/tb_csa_resolve.sv
// tb_csa_resolve
// Bench for csa_resolve (WIDTH=16, SEG=4): directed cases followed by a
// random stream, compared against an arithmetic reference model queue.
module tb_csa_resolve;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] sum_vec;
  logic [W-1:0] carry_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  csa_resolve dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum_vec  (sum_vec),
    .carry_vec(carry_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry_out(carry_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         o;
    int           t;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] emitted[$];
  int           n_pass  = 0;
  int           n_total = 0;
  int           cyc     = 0;
  logic         chk_lat = 1'b0;
  logic         last_in_fire = 1'b0;
  logic [W-1:0] last_res;
  logic         last_cout;
  logic         last_ovf;

  // Reference: plain integer arithmetic on the operand values
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [W:0]  u;
    int          sa;
    int          sb;
    int          ss;
    u    = {1'b0, a} + {1'b0, b};
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    ss   = sa + sb;
    e.c  = u[W];
    e.o  = (ss > 32767) || (ss < -32768);
    e.r  = u[W-1:0];
`ifdef CSA_RESOLVE_SAT_EN
    if (e.o) e.r = (ss > 0) ? 16'h7FFF : 16'h8000;
`endif
    e.t  = 0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: entered at posedge+1 with inputs already driven.
  task automatic cycle();
    logic inf;
    logic outf;
    exp_t e;
    #1;
    inf  = in_valid && in_ready && !rst;
    outf = out_valid && out_ready && !rst;
    if (outf) begin
      check("out_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("result", 32'(result), 32'(e.r));
        check("carry_out", 32'(carry_out), 32'(e.c));
        check("overflow", 32'(overflow), 32'(e.o));
        if (chk_lat) check("latency", 32'(cyc - e.t), 32'd4);
      end
      last_res  = result;
      last_cout = carry_out;
      last_ovf  = overflow;
      emitted.push_back(result);
    end
    if (inf) begin
      e   = model(sum_vec, carry_vec);
      e.t = cyc;
      q.push_back(e);
    end
    last_in_fire = inf;
    @(posedge clk);
    cyc++;
    if (rst) q.delete();
    #1;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    for (int k = 0; k < max_cyc && q.size() > 0; k++) cycle();
    check({"drain_", tag}, 32'(q.size()), 32'd0);
  endtask

  task automatic send_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid  = 1'b1;
    sum_vec   = a;
    carry_vec = b;
    out_ready = 1'b1;
    cycle();
    for (int k = 0; k < 10 && !last_in_fire; k++) cycle();
    check({"accepted_", tag}, 32'(last_in_fire), 32'd1);
    in_valid = 1'b0;
    drain(tag, 20);
  endtask

  initial begin
    int i;
    int stall_left;
    logic stalled_once;
    int sent;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sum_vec = '0; carry_vec = '0;
    @(posedge clk); #1;
    cycle(); cycle(); cycle();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry_out", 32'(carry_out), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed arithmetic with exact latency
    chk_lat = 1'b1;
    send_one("basic", 16'h1234, 16'h0001);
    check("basic_res", 32'(last_res), 32'h1235);
    check("basic_cout", 32'(last_cout), 32'd0);
    check("basic_ovf", 32'(last_ovf), 32'd0);

    send_one("ripple", 16'hFFFF, 16'h0001);
    check("ripple_res", 32'(last_res), 32'h0000);
    check("ripple_cout", 32'(last_cout), 32'd1);
    check("ripple_ovf", 32'(last_ovf), 32'd0);

    send_one("povf", 16'h7FFF, 16'h0001);
`ifdef CSA_RESOLVE_SAT_EN
    check("povf_res", 32'(last_res), 32'h7FFF);
`else
    check("povf_res", 32'(last_res), 32'h8000);
`endif
    check("povf_ovf", 32'(last_ovf), 32'd1);
    check("povf_cout", 32'(last_cout), 32'd0);

    send_one("novf", 16'h8000, 16'h8000);
`ifdef CSA_RESOLVE_SAT_EN
    check("novf_res", 32'(last_res), 32'h8000);
`else
    check("novf_res", 32'(last_res), 32'h0000);
`endif
    check("novf_cout", 32'(last_cout), 32'd1);
    check("novf_ovf", 32'(last_ovf), 32'd1);

    // Backpressure: six pairs (i, 2i), 3-cycle stall when out_valid rises
    chk_lat = 1'b0;
    emitted.delete();
    i = 1; stall_left = 0; stalled_once = 1'b0;
    for (int c = 0; c < 60 && (i <= 6 || q.size() > 0); c++) begin
      in_valid  = (i <= 6);
      sum_vec   = 16'(i);
      carry_vec = 16'(2 * i);
      if (!stalled_once && out_valid) begin
        stalled_once = 1'b1;
        stall_left   = 3;
      end
      out_ready = (stall_left == 0);
      if (stall_left > 0) begin
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      cycle();
      if (last_in_fire) i++;
      if (stall_left > 0) stall_left--;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_stall_seen", 32'(stalled_once), 32'd1);
    check("bp_count", 32'(emitted.size()), 32'd6);
    for (int k = 0; k < 6 && k < emitted.size(); k++)
      check("bp_order", 32'(emitted[k]), 32'(3 * (k + 1)));

    // Reset with three tokens in flight
    for (int k = 1; k <= 3; k++) begin
      in_valid  = 1'b1;
      sum_vec   = 16'(16'h0100 * k);
      carry_vec = 16'(k);
      cycle();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    emitted.delete();
    for (int k = 0; k < 10; k++) cycle();
    check("midrst_no_output", 32'(emitted.size()), 32'd0);
    chk_lat = 1'b1;
    send_one("post_rst", 16'h0100, 16'h0023);
    check("post_rst_res", 32'(last_res), 32'h0123);
    chk_lat = 1'b0;

    // Random stream with random valid/ready
    sent = 0;
    in_valid = 1'b0;
    last_in_fire = 1'b0;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      if (!in_valid || last_in_fire) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        sum_vec   = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
        carry_vec = ($urandom_range(0, 7) == 0) ? 16'h8001 : 16'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
      if (last_in_fire) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rand_sent", 32'(sent), 32'd10000);
    drain("random", 50);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
